// File: rtl/clkdiv_pkg.sv
// Shared types, defaults and the ratio validity rule for the fractional clock divider.
package clkdiv_pkg;

    localparam int CLKDIV_W         = 32;
    localparam int CLKDIV_DEF_FENZI = 2;
    localparam int CLKDIV_DEF_FENMU = 1;
    // Widest ratio the validity helper handles; narrower ratios are zero-extended.
    localparam int RATIO_MAXW       = 64;

    typedef logic [2:0] clkdiv_state_t;

    localparam logic [2:0] ST_INIT      = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_WAIT_SAFE = 3'd3;
    localparam logic [2:0] ST_APPLY     = 3'd4;
    localparam logic [2:0] ST_LOCK      = 3'd5;

    // Divider needs fenzi >= 2*fenmu; the extra top bit keeps 2*fenmu from overflowing.
    function automatic logic ratio_ok(input logic [RATIO_MAXW-1:0] fz,
                                      input logic [RATIO_MAXW-1:0] fm);
        return (fm != '0) && ({1'b0, fz} >= {fm, 1'b0});
    endfunction

endpackage

// File: rtl/clkdiv_edge_det.sv
// Registers a monitored clock in the refclk domain and flags its rising/falling edges.
module clkdiv_edge_det (
    input  logic refclk,
    input  logic rstn_syn,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic clk_d_q;

    always_ff @(posedge refclk or negedge rstn_syn) begin
        if (!rstn_syn) clk_d_q <= 1'b0;
        else           clk_d_q <= sig_i;
    end

    assign rise_o = ~clk_d_q &  sig_i;
    assign fall_o =  clk_d_q & ~sig_i;

endmodule

// File: rtl/clkdiv_cfg_ctrl.sv
// Ratio-update controller: validates requests, applies them on a clkout falling edge, tracks lock.
// Build option CLKDIV_LOCK_DET_EN: lock requires LOCK_EDGES clkout rises within TIMEOUT cycles.
module clkdiv_cfg_ctrl
    import clkdiv_pkg::*;
#(
    parameter int W          = CLKDIV_W,
    parameter int DEF_FENZI  = CLKDIV_DEF_FENZI,
    parameter int DEF_FENMU  = CLKDIV_DEF_FENMU,
    parameter int TIMEOUT    = 1024,
    parameter int LOCK_EDGES = 4
) (
    input  logic         refclk,
    input  logic         rstn_syn,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_fenzi,
    input  logic [W-1:0] cfg_fenmu,
    output logic         cfg_done,
    output logic         cfg_err,
    input  logic         clkout_mon,
    output logic [W-1:0] fenzi,
    output logic [W-1:0] fenmu,
    output logic         locked
);

    localparam int            TW   = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    clkdiv_state_t state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [W-1:0]  fz_s_q, fz_s_d, fm_s_q, fm_s_d;
    logic [W-1:0]  fz_q, fz_d, fm_q, fm_d;
    logic          locked_q, locked_d;
    logic          done, err;
    logic          rise, fall, tmo;
    logic          lock_hit;

    clkdiv_edge_det u_edge (
        .refclk   (refclk),
        .rstn_syn (rstn_syn),
        .sig_i    (clkout_mon),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    assign tmo = (tcnt_q == TMAX);

`ifdef CLKDIV_LOCK_DET_EN
    localparam int EW = $clog2(LOCK_EDGES + 1);
    logic [EW-1:0] ecnt_q, ecnt_d;

    assign lock_hit = rise && (ecnt_q == EW'(LOCK_EDGES - 1));

    always_comb begin
        ecnt_d = ecnt_q;
        if (state_d != state_q) ecnt_d = '0;
        else if (rise)          ecnt_d = ecnt_q + 1'b1;
    end

    always_ff @(posedge refclk or negedge rstn_syn) begin
        if (!rstn_syn) ecnt_q <= '0;
        else           ecnt_q <= ecnt_d;
    end
`else
    // Without detection the divider is trusted to be running one cycle after an apply.
    logic unused_lock;
    assign unused_lock = rise ^ LOCK_EDGES[0];
    assign lock_hit    = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        fz_s_d   = fz_s_q;
        fm_s_d   = fm_s_q;
        fz_d     = fz_q;
        fm_d     = fm_q;
        locked_d = locked_q;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            ST_INIT, ST_LOCK: begin
                if (lock_hit) begin
                    locked_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (tmo) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cfg_valid) begin
                    fz_s_d  = cfg_fenzi;
                    fm_s_d  = cfg_fenmu;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!ratio_ok(RATIO_MAXW'(fz_s_q), RATIO_MAXW'(fm_s_q))) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else if (fz_s_q == fz_q && fm_s_q == fm_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    locked_d = 1'b0;
                    state_d  = ST_WAIT_SAFE;
                end
            end
            ST_WAIT_SAFE: begin
                if (fall || tmo) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                fz_d    = fz_s_q;
                fm_d    = fm_s_q;
                done    = 1'b1;
                state_d = ST_LOCK;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Timer restarts on every state entry and saturates so long idles cannot wrap it.
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_d != state_q) tcnt_d = '0;
        else if (!tmo)          tcnt_d = tcnt_q + 1'b1;
    end

    always_ff @(posedge refclk or negedge rstn_syn) begin
        if (!rstn_syn) begin
            state_q  <= ST_INIT;
            tcnt_q   <= '0;
            fz_s_q   <= '0;
            fm_s_q   <= '0;
            fz_q     <= W'(DEF_FENZI);
            fm_q     <= W'(DEF_FENMU);
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            fz_s_q   <= fz_s_d;
            fm_s_q   <= fm_s_d;
            fz_q     <= fz_d;
            fm_q     <= fm_d;
            locked_q <= locked_d;
        end
    end

    assign cfg_ready = (state_q == ST_IDLE);
    assign cfg_done  = done;
    assign cfg_err   = err;
    assign fenzi     = fz_q;
    assign fenmu     = fm_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Scoreboard bench for clkdiv_cfg_ctrl; expectations follow CLKDIV_LOCK_DET_EN when defined.
module tb_clkdiv_cfg_ctrl;

    localparam int W          = 32;
    localparam int TIMEOUT    = 1024;
    localparam int LOCK_EDGES = 4;

    logic         refclk = 1'b0;
    logic         rstn_syn = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_fenzi = '0;
    logic [W-1:0] cfg_fenmu = '0;
    logic         clkout_mon = 1'b0;
    logic         cfg_ready, cfg_done, cfg_err, locked;
    logic [W-1:0] fenzi, fenmu;

    always #5 refclk = ~refclk;

    clkdiv_cfg_ctrl #(.W(W), .DEF_FENZI(2), .DEF_FENMU(1),
                      .TIMEOUT(TIMEOUT), .LOCK_EDGES(LOCK_EDGES)) dut (
        .refclk     (refclk),
        .rstn_syn   (rstn_syn),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_fenzi  (cfg_fenzi),
        .cfg_fenmu  (cfg_fenmu),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .clkout_mon (clkout_mon),
        .fenzi      (fenzi),
        .fenmu      (fenmu),
        .locked     (locked)
    );

    typedef struct packed {
        logic         is_err;
        logic         chk_fall;
        logic [W-1:0] fz;
        logic [W-1:0] fm;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t pend;
    bit   pend_v = 1'b0;
    bit   clk_run = 1'b0;
    int   rises = 0;
    logic mon_p = 1'b0, mon_pp = 1'b0;

    // Divider clkout stand-in: toggles every 3 refclk cycles, held low when stopped.
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge refclk);
            if (!clk_run) begin
                clkout_mon = 1'b0;
                c = 0;
            end else begin
                c++;
                if (c == 3) begin
                    c = 0;
                    clkout_mon = ~clkout_mon;
                end
            end
        end
    end

    // clkout history as seen at refclk edges, used to model edge events.
    always @(posedge refclk) begin
        if (!rstn_syn) begin
            mon_p  <= 1'b0;
            mon_pp <= 1'b0;
            rises  <= 0;
        end else begin
            mon_pp <= mon_p;
            mon_p  <= clkout_mon;
            if (!mon_p && clkout_mon) rises <= rises + 1;
        end
    end

    // Response monitor: pops one expectation per done/err pulse, checks ratio a cycle later.
    always @(negedge refclk) begin
        if (rstn_syn) begin
            if (pend_v) begin
                checks++;
                if (fenzi !== pend.fz || fenmu !== pend.fm) begin
                    errors++;
                    $display("FAIL ratio_out got %0d/%0d exp %0d/%0d", fenzi, fenmu, pend.fz, pend.fm);
                end
                pend_v = 1'b0;
            end
            if (cfg_done || cfg_err) begin
                checks++;
                if (cfg_done && cfg_err) begin
                    errors++;
                    $display("FAIL done_err_overlap both high");
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse done=%0b err=%0b", cfg_done, cfg_err);
                end else begin
                    pend = sb.pop_front();
                    if (cfg_err !== pend.is_err) begin
                        errors++;
                        $display("FAIL resp_kind err=%0b exp %0b", cfg_err, pend.is_err);
                    end else if (pend.chk_fall && !(mon_pp === 1'b1 && mon_p === 1'b0)) begin
                        errors++;
                        $display("FAIL apply_at_fall clkout hist=%0b%0b exp 10", mon_pp, mon_p);
                    end
                    pend_v = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] fz, input logic [W-1:0] fm, input logic is_err,
                        input logic [W-1:0] efz, input logic [W-1:0] efm, input logic chk_fall);
        exp_t e;
        bit   acc;
        e.is_err = is_err; e.chk_fall = chk_fall; e.fz = efz; e.fm = efm;
        sb.push_back(e);
        @(negedge refclk);
        cfg_valid = 1'b1; cfg_fenzi = fz; cfg_fenmu = fm;
        acc = 1'b0;
        for (int i = 0; i < 4000 && !acc; i++) begin
            if (cfg_ready) begin
                @(posedge refclk);
                #1;
                acc = 1'b1;
            end else begin
                @(negedge refclk);
            end
        end
        cfg_valid = 1'b0;
        cfg_fenzi = W'($urandom);
        cfg_fenmu = W'($urandom);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout req %0d/%0d ready=%0b exp 1", fz, fm, cfg_ready);
        end
    endtask

    task automatic wait_resp(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || pend_v) && n < budget) begin
            @(negedge refclk);
            #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL resp_timeout pending=%0d exp 0", sb.size());
        end
    endtask

    task automatic wait_locked(input int budget, output int n);
        n = 0;
        while (!locked && n < budget) begin
            @(negedge refclk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        rstn_syn = 1'b0;
        clk_run  = 1'b1;
        repeat (3) @(negedge refclk);
        #1;
        checks += 6;
        if (fenzi !== 2)      begin errors++; $display("FAIL rst_fenzi got %0d exp 2", fenzi); end
        if (fenmu !== 1)      begin errors++; $display("FAIL rst_fenmu got %0d exp 1", fenmu); end
        if (cfg_ready !== 0)  begin errors++; $display("FAIL rst_ready got %0b exp 0", cfg_ready); end
        if (cfg_done !== 0)   begin errors++; $display("FAIL rst_done got %0b exp 0", cfg_done); end
        if (cfg_err !== 0)    begin errors++; $display("FAIL rst_err got %0b exp 0", cfg_err); end
        if (locked !== 0)     begin errors++; $display("FAIL rst_locked got %0b exp 0", locked); end
        @(negedge refclk);
        rstn_syn = 1'b1;
        wait_locked(300, n);
        checks++;
        if (!locked) begin errors++; $display("FAIL init_lock locked=%0b exp 1", locked); end
`ifdef CLKDIV_LOCK_DET_EN
        checks++;
        if (rises !== LOCK_EDGES) begin
            errors++; $display("FAIL init_lock_edges got %0d exp %0d", rises, LOCK_EDGES);
        end
`else
        checks++;
        if (n > 2) begin errors++; $display("FAIL init_lock_cycles got %0d exp <=2", n); end
`endif
    endtask

    task automatic test_new_ratio;
        int n;
        send(19, 9, 1'b0, 19, 9, 1'b1);
        @(negedge refclk); @(negedge refclk); #1;
        checks++;
        if (locked !== 0) begin errors++; $display("FAIL unlock_on_new got %0b exp 0", locked); end
        wait_resp(200);
        wait_locked(300, n);
        checks++;
        if (!locked) begin errors++; $display("FAIL relock_19_9 locked=%0b exp 1", locked); end
    endtask

    task automatic test_reject;
        int n;
        logic [W-1:0] big;
        send(3, 2, 1'b1, 19, 9, 1'b0);
        wait_resp(50);
        checks += 2;
        if (cfg_ready !== 1) begin errors++; $display("FAIL ready_after_err got %0b exp 1", cfg_ready); end
        if (locked !== 1)    begin errors++; $display("FAIL lock_after_err got %0b exp 1", locked); end
        send(5, 0, 1'b1, 19, 9, 1'b0);
        wait_resp(50);
        big = 32'h8000_0000;
        send(32'hFFFF_FFFF, big, 1'b1, 19, 9, 1'b0);
        wait_resp(50);
        send(18, 9, 1'b0, 18, 9, 1'b1);
        wait_resp(200);
        wait_locked(300, n);
        send(19, 9, 1'b0, 19, 9, 1'b1);
        wait_resp(200);
        wait_locked(300, n);
        checks++;
        if (!locked) begin errors++; $display("FAIL relock_boundary locked=%0b exp 1", locked); end
    endtask

    task automatic test_same_ratio;
        bit dropped;
        send(19, 9, 1'b0, 19, 9, 1'b0);
        @(negedge refclk); #1;
        checks++;
        if (cfg_done !== 1) begin errors++; $display("FAIL same_done_cycle1 got %0b exp 1", cfg_done); end
        dropped = 1'b0;
        repeat (6) begin
            if (!locked) dropped = 1'b1;
            @(negedge refclk); #1;
        end
        checks++;
        if (dropped) begin errors++; $display("FAIL same_lock_drop got 1 exp 0"); end
        wait_resp(20);
    endtask

    task automatic test_timeout;
        int n;
        int n2;
        clk_run = 1'b0;
        repeat (4) @(negedge refclk);
        send(8, 1, 1'b0, 8, 1, 1'b0);
`ifdef CLKDIV_LOCK_DET_EN
        begin
            exp_t e;
            e.is_err = 1'b1; e.chk_fall = 1'b0; e.fz = 8; e.fm = 1;
            sb.push_back(e);
        end
`endif
        n = 0;
        while (!cfg_done && n < 3000) begin @(negedge refclk); #1; n++; end
        checks++;
        if (n !== TIMEOUT + 2) begin
            errors++; $display("FAIL safe_timeout cycles got %0d exp %0d", n, TIMEOUT + 2);
        end
`ifdef CLKDIV_LOCK_DET_EN
        n2 = 0;
        while (!cfg_err && n2 < 3000) begin @(negedge refclk); #1; n2++; end
        checks += 2;
        if (n2 !== TIMEOUT) begin
            errors++; $display("FAIL lock_timeout cycles got %0d exp %0d", n2, TIMEOUT);
        end
        if (locked !== 0) begin errors++; $display("FAIL lock_timeout_locked got %0b exp 0", locked); end
`else
        wait_locked(5, n2);
        checks++;
        if (locked !== 1 || n2 > 2) begin
            errors++; $display("FAIL apply_lock got %0b after %0d exp 1 within 2", locked, n2);
        end
`endif
        wait_resp(20);
    endtask

    task automatic test_reset_mid;
        int  n;
        bit  pulse;
        send(3, 1, 1'b0, 3, 1, 1'b0);
        repeat (10) @(negedge refclk);
        rstn_syn = 1'b0;
        #1;
        sb.delete();
        pend_v = 1'b0;
        checks += 6;
        if (fenzi !== 2)     begin errors++; $display("FAIL mid_rst_fenzi got %0d exp 2", fenzi); end
        if (fenmu !== 1)     begin errors++; $display("FAIL mid_rst_fenmu got %0d exp 1", fenmu); end
        if (cfg_ready !== 0) begin errors++; $display("FAIL mid_rst_ready got %0b exp 0", cfg_ready); end
        if (locked !== 0)    begin errors++; $display("FAIL mid_rst_locked got %0b exp 0", locked); end
        if (cfg_done !== 0)  begin errors++; $display("FAIL mid_rst_done got %0b exp 0", cfg_done); end
        if (cfg_err !== 0)   begin errors++; $display("FAIL mid_rst_err got %0b exp 0", cfg_err); end
        pulse = 1'b0;
        repeat (4) begin
            @(negedge refclk); #1;
            if (cfg_done || cfg_err) pulse = 1'b1;
        end
        clk_run  = 1'b1;
        rstn_syn = 1'b1;
        wait_locked(300, n);
        checks += 3;
        if (pulse)           begin errors++; $display("FAIL mid_rst_pulse got 1 exp 0"); end
        if (!locked)         begin errors++; $display("FAIL mid_rst_relock got %0b exp 1", locked); end
        if (fenzi !== 2 || fenmu !== 1) begin
            errors++; $display("FAIL mid_rst_ratio got %0d/%0d exp 2/1", fenzi, fenmu);
        end
        send(19, 9, 1'b0, 19, 9, 1'b1);
        wait_resp(200);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_new_ratio();
        test_reject();
        test_same_ratio();
        test_timeout();
        test_reset_mid();
        repeat (4) @(negedge refclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_cfg_ctrl.md
Name: clkdiv_cfg_ctrl

Overview:
Runtime configuration controller for the fractional clock divider. Accepts ratio-update requests (fenzi/fenmu) over a valid/ready handshake, validates them, and holds them until a safe point. The safe point is the falling edge of the divider output. The controller then drives the divider's fenzi/fenmu inputs and reports completion and lock status. It sits between the register/CPU side and the divider instance, in the refclk domain.

Parameters:
W, 32, width of fenzi/fenmu.
DEF_FENZI, 2, fenzi driven from reset.
DEF_FENMU, 1, fenmu driven from reset.
TIMEOUT, 1024, max refclk cycles to wait for a safe point or lock, >= 4.
LOCK_EDGES, 4, clkout rising edges required for lock (CLKDIV_LOCK_DET_EN only), >= 1.

Ports:
refclk  in  1  clock.
rstn_syn  in  1  reset, asynchronous, active-low.
cfg_valid  in  1  request valid.
cfg_ready  out  1  request accepted when valid&ready.
cfg_fenzi  in  W  requested numerator.
cfg_fenmu  in  W  requested denominator.
cfg_done  out  1  1-cycle pulse: new ratio applied.
cfg_err  out  1  1-cycle pulse: request rejected, or lock timeout.
clkout_mon  in  1  divider clkout, registered in refclk domain.
fenzi  out  W  to divider.
fenmu  out  W  to divider.
locked  out  1  divider running at current ratio.

Behaviour:
- Reset values: fenzi=DEF_FENZI, fenmu=DEF_FENMU, cfg_ready=0, cfg_done=0, cfg_err=0, locked=0, state=INIT.
- Internal clk_d flop samples clkout_mon; reset value 0.
  - fall = clk_d & ~clkout_mon.
  - rise = ~clk_d & clkout_mon.
- Internal timer tcnt, width clog2(TIMEOUT)+1; cleared on every state entry.
- States:
  - INIT: lock check of the default ratio, identical to LOCK. Exits to IDLE.
  - IDLE: cfg_ready=1; this is the only state with ready high. On valid&ready, capture cfg_fenzi/cfg_fenmu into shadow regs, go to CHECK.
  - CHECK (1 cycle): valid iff fenmu_s != 0 and {1'b0,fenzi_s} >= {fenmu_s,1'b0}, evaluated in W+1 bits with no overflow.
    - Invalid: cfg_err pulse this cycle, go to IDLE; fenzi/fenmu unchanged.
    - Valid and shadow equals current fenzi/fenmu: cfg_done pulse, go to IDLE; locked unaffected.
    - Otherwise: go to WAIT_SAFE; locked drops to 0 on this transition.
  - WAIT_SAFE: on fall, or tcnt==TIMEOUT-1, go to APPLY.
  - APPLY (1 cycle): fenzi/fenmu <= shadow (visible next cycle), cfg_done pulse, go to LOCK.
  - LOCK: see Optional Feature; exits to IDLE.
- Latency for a valid new ratio: accept at cycle 0; CHECK at cycle 1; WAIT_SAFE from cycle 2. A fall in cycle k gives APPLY in k+1 and new outputs from k+2.
- cfg_fenzi/cfg_fenmu changes while not accepting are ignored.
- cfg_done and cfg_err are never high in the same cycle.
- Reset mid-operation: all state returns to reset values immediately (async); a pending shadow request is discarded and no done/err is emitted.

Optional Feature:
CLKDIV_LOCK_DET_EN
- Defined: LOCK counts rise events. locked=1 and go to IDLE when the count reaches LOCK_EDGES. If tcnt==TIMEOUT-1 first: cfg_err pulse, locked stays 0, go to IDLE.
- Undefined: LOCK lasts 1 cycle, sets locked=1, goes to IDLE.
  - Reset to locked=1 takes 2 cycles after rstn_syn release (INIT→LOCK path collapses to 1 cycle).

Decomposition:
- Package clkdiv_pkg:
  - W default
  - state enum {INIT, IDLE, CHECK, WAIT_SAFE, APPLY, LOCK}
  - DEF_FENZI/DEF_FENMU constants
  - ratio_ok function implementing the CHECK rule
- One natural sub-module: clkdiv_edge_det (clk_d flop plus rise/fall outputs), reusable by other clkout monitors.

Test Plan:
1. Reset release with lock det, divider at 2/1 → fenzi=2, fenmu=1; locked=1 after 4 clkout rises; no cfg_err.
2. Request 19/9 → cfg_done one cycle after the first clkout fall following accept; fenzi=19, fenmu=9 next cycle; locked 0 then 1.
3. Request 3/2 (3 < 4) and 5/0 → cfg_err pulse in CHECK; outputs stay 19/9; locked stays 1; cfg_ready back high next cycle.
4. Request 19/9 while current is 19/9 → cfg_done at cycle 1; locked never drops.
5. clkout_mon held 0, request 8/1 → APPLY after TIMEOUT=1024 cycles; then, with lock det, cfg_err after another 1024 cycles with locked=0.
6. Assert rstn_syn low during WAIT_SAFE → outputs 2/1 immediately, cfg_ready=0, no done/err; after release, normal INIT sequence.
